// File: rtl/dpram_sdp_ctrl.sv
// dpram_sdp_ctrl: simple dual-port RAM with one write port and one read port
// on a shared clock.
//
// The array is DATA_W bits wide and 2**ADDR_W words deep, with a write enable
// per byte lane. Read latency is 1, or 2 when OUT_REG=1. RDW_MODE selects what
// a same-address read returns when it shares an edge with a write. After every
// reset a clear engine writes INIT_VAL to every word through the write port.
// User accesses are ignored while the clear engine runs.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset; restarts the clear engine
//   data       write data
//   wraddress  write address
//   wren       write enable
//   byteena    per-lane write enable; bit b covers data[8b+7:8b]
//   rdaddress  read address
//   rden       read enable
//   q          read data; holds its last value between reads
//   rdvalid    one-cycle strobe marking q as the result of an accepted read
//   busy       high while the clear engine runs (this is the CLEAR state)
//
// Read handshake: a read is accepted at an edge where rden=1 and busy=0.
// There is no back-pressure, so one read can be accepted on every edge.
// Each accepted read produces exactly one rdvalid pulse, in order, 1 or 2
// cycles later (OUT_REG). A reset discards any read still in the pipeline.
module dpram_sdp_ctrl #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                OUT_REG  = 0,
    parameter int                RDW_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     data,
    input  logic [ADDR_W-1:0]     wraddress,
    input  logic                  wren,
    input  logic [DATA_W/8-1:0]   byteena,
    input  logic [ADDR_W-1:0]     rdaddress,
    input  logic                  rden,
    output logic [DATA_W-1:0]     q,
    output logic                  rdvalid,
    output logic                  busy
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    logic              clearing, user_ok, wr_acc, rd_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [NB-1:0]     mem_be;

    logic [NB-1:0][7:0] mem [DEPTH];
    logic [DATA_W-1:0]  ram_rd_data;

    logic              v1_q, v1_d, v2_q, v2_d, has_q, has_d;
    logic              byp_hit_q, byp_hit_d;
    logic [NB-1:0]     byp_be_q, byp_be_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] rd_word;

    // Clear sequencer: one word per edge, then READY until the next reset.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_READY;
                end
            end
            default: ;
        endcase
    end

    // Write-port arbitration. A reset edge performs no write of either kind,
    // so the first INIT_VAL lands on the edge after reset is released.
    always_comb begin
        clearing = (state_q == ST_CLEAR) && !reset;
        user_ok  = (state_q == ST_READY) && !reset;
        wr_acc   = user_ok && wren;
        rd_acc   = user_ok && rden;
        mem_we   = clearing || wr_acc;
        mem_wa   = clearing ? clr_ptr_q : wraddress;
        mem_wd   = clearing ? INIT_VAL  : data;
        mem_be   = clearing ? {NB{1'b1}} : byteena;
    end

    // Read pipeline and outputs. The RAM read register always returns
    // old data. New-data mode is provided by remembering the colliding
    // write's lanes and data, and merging them over the RAM word afterwards.
    // This keeps the array a plain block RAM.
    always_comb begin
        v1_d       = rd_acc;
        v2_d       = v1_q;
        has_d      = has_q || rd_acc;
        byp_hit_d  = byp_hit_q;
        byp_be_d   = byp_be_q;
        byp_data_d = byp_data_q;
        if (rd_acc) begin
            byp_hit_d  = (RDW_MODE != 0) && wr_acc && (wraddress == rdaddress);
            byp_be_d   = byteena;
            byp_data_d = data;
        end

        rd_word = ram_rd_data;
        for (int b = 0; b < NB; b++) begin
            if (byp_hit_q && byp_be_q[b]) begin
                rd_word[8*b +: 8] = byp_data_q[8*b +: 8];
            end
        end

        out_d = v1_q ? rd_word : out_q;

        // The RAM register has no reset. At latency 1, q is forced to 0
        // until the first read after reset has completed.
        if (OUT_REG != 0) begin
            q       = out_q;
            rdvalid = v2_q;
        end else begin
            q       = has_q ? rd_word : '0;
            rdvalid = v1_q;
        end
        busy = (state_q == ST_CLEAR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            has_q      <= 1'b0;
            byp_hit_q  <= 1'b0;
            byp_be_q   <= '0;
            byp_data_q <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            has_q      <= has_d;
            byp_hit_q  <= byp_hit_d;
            byp_be_q   <= byp_be_d;
            byp_data_q <= byp_data_d;
            out_q      <= out_d;
        end
    end

    // Storage array: byte-enabled write port and clock-enabled read register.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem[mem_wa][b] <= mem_wd[8*b +: 8];
                end
            end
        end
        if (rd_acc) begin
            ram_rd_data <= mem[rdaddress];
        end
    end

endmodule

// File: tb/tb_dpram_sdp_ctrl.sv
`timescale 1ns/1ps
// Testbench for dpram_sdp_ctrl. Three configurations are driven from one
// shared set of inputs:
//   a: 8-bit,  read latency 1, old-data RDW, INIT 8'h00
//   b: 8-bit,  read latency 2, new-data RDW, INIT 8'h00
//   c: 16-bit, read latency 2, new-data RDW, INIT 16'hA5C3
module tb_dpram_sdp_ctrl;
    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset, wren, rden;
    logic [15:0] data;
    logic [7:0]  wraddress, rdaddress;
    logic [1:0]  byteena;
    logic [7:0]  q_a, q_b;
    logic [15:0] q_c;
    logic        rv_a, rv_b, rv_c, busy_a, busy_b, busy_c;

    always #5 clock = ~clock;

    dpram_sdp_ctrl #(.DATA_W(8), .ADDR_W(8), .OUT_REG(0), .RDW_MODE(0), .INIT_VAL(8'h00)) u_a (
        .clock(clock), .reset(reset), .data(data[7:0]), .wraddress(wraddress), .wren(wren),
        .byteena(byteena[0:0]), .rdaddress(rdaddress), .rden(rden), .q(q_a), .rdvalid(rv_a),
        .busy(busy_a));
    dpram_sdp_ctrl #(.DATA_W(8), .ADDR_W(8), .OUT_REG(1), .RDW_MODE(1), .INIT_VAL(8'h00)) u_b (
        .clock(clock), .reset(reset), .data(data[7:0]), .wraddress(wraddress), .wren(wren),
        .byteena(byteena[0:0]), .rdaddress(rdaddress), .rden(rden), .q(q_b), .rdvalid(rv_b),
        .busy(busy_b));
    dpram_sdp_ctrl #(.DATA_W(16), .ADDR_W(8), .OUT_REG(1), .RDW_MODE(1), .INIT_VAL(16'hA5C3)) u_c (
        .clock(clock), .reset(reset), .data(data), .wraddress(wraddress), .wren(wren),
        .byteena(byteena), .rdaddress(rdaddress), .rden(rden), .q(q_c), .rdvalid(rv_c),
        .busy(busy_c));

    logic [15:0] dout [3];
    logic        rv [3];
    logic        bz [3];
    assign dout[0] = {8'h00, q_a};
    assign dout[1] = {8'h00, q_b};
    assign dout[2] = q_c;
    assign rv[0] = rv_a;
    assign rv[1] = rv_b;
    assign rv[2] = rv_c;
    assign bz[0] = busy_a;
    assign bz[1] = busy_b;
    assign bz[2] = busy_c;

    // Per-instance configuration seen by the reference model.
    int          lat [3];
    logic        rdw [3];
    int          nb [3];
    logic [15:0] init_v [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: a word array per instance, a countdown of clear
    // cycles, and a queue of read results tagged with the edge index at
    // which each one must appear on q.
    typedef struct packed {
        int          due;
        logic [15:0] d;
    } pend_t;
    pend_t       exp_q [3][$];
    logic [15:0] mem_m [3][DEPTH];
    int          busy_left [3];
    logic [15:0] exp_dout [3];
    logic        exp_rv [3];

    task automatic model_edge();
        logic [15:0] new_w, rd_w;
        pend_t p;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            exp_rv[k] = 1'b0;
            if (reset) begin
                busy_left[k] = DEPTH;
                exp_q[k].delete();
                exp_dout[k] = 16'h0000;
            end else if (busy_left[k] > 0) begin
                mem_m[k][DEPTH - busy_left[k]] = init_v[k];
                busy_left[k]--;
            end else begin
                new_w = mem_m[k][wraddress];
                for (int b = 0; b < nb[k]; b++) begin
                    if (byteena[b]) new_w[8*b +: 8] = data[8*b +: 8];
                end
                rd_w = (rdw[k] && wren && rdaddress == wraddress) ? new_w : mem_m[k][rdaddress];
                if (rden) begin
                    p.due = cyc + lat[k] - 1;
                    p.d   = rd_w;
                    exp_q[k].push_back(p);
                end
                if (wren) mem_m[k][wraddress] = new_w;
                if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
                    p = exp_q[k].pop_front();
                    exp_dout[k] = p.d;
                    exp_rv[k]   = 1'b1;
                end
            end
        end
    endtask

    // Advance one clock. The model sees the inputs that were sampled at the
    // edge. Outputs are then read 1ns later.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    // Capture buffers for back-to-back read bursts.
    logic [15:0] got [3][$];
    int          first_t [3];
    int          last_t [3];

    task automatic burst_read(input int base, input int n);
        for (int k = 0; k < 3; k++) begin
            got[k].delete();
            first_t[k] = -1;
            last_t[k]  = -1;
        end
        for (int t = 0; t < n + 3; t++) begin
            rden      = (t < n);
            rdaddress = 8'(base + t);
            step();
            for (int k = 0; k < 3; k++) begin
                if (rv[k]) begin
                    if (first_t[k] < 0) first_t[k] = t;
                    last_t[k] = t;
                    got[k].push_back(dout[k]);
                end
            end
        end
        rden = 1'b0;
    endtask

    task automatic test_reset();
        int cnt [3];
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dout[k] !== 16'h0000 || rv[k] !== 1'b0 || bz[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: q=%h rdvalid=%b busy=%b, want q=0 rdvalid=0 busy=1",
                         k, dout[k], rv[k], bz[k]);
            end
        end
        cnt = '{0, 0, 0};
        for (int t = 0; t < 300; t++) begin
            for (int k = 0; k < 3; k++) if (bz[k]) cnt[k]++;
            if (!bz[0] && !bz[1] && !bz[2]) break;
            step();
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (cnt[k] != DEPTH) begin
                n_bad++;
                $display("FAIL busy_cycles[%0d]: got %0d, want %0d", k, cnt[k], DEPTH);
            end
        end
    endtask

    task automatic test_clear_contents();
        burst_read(0, 16);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (got[k].size() != 16 || first_t[k] != lat[k] - 1 || last_t[k] - first_t[k] != 15) begin
                n_bad++;
                $display("FAIL clear_burst_timing[%0d]: pulses=%0d latency=%0d span=%0d, want 16 %0d 15",
                         k, got[k].size(), first_t[k] + 1, last_t[k] - first_t[k], lat[k]);
            end
            for (int i = 0; i < got[k].size() && i < 16; i++) begin
                n_cmp++;
                if (got[k][i] !== init_v[k]) begin
                    n_bad++;
                    $display("FAIL clear_value[%0d] addr %0d: got %h, want %h", k, i, got[k][i], init_v[k]);
                end
            end
        end
    endtask

    task automatic test_burst();
        wren    = 1'b1;
        byteena = 2'b11;
        for (int i = 0; i < 16; i++) begin
            wraddress = 8'(i);
            data      = 16'(255 - i);
            step();
        end
        wren = 1'b0;
        repeat (20) step();
        burst_read(0, 16);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (got[k].size() != 16 || first_t[k] != lat[k] - 1 || last_t[k] - first_t[k] != 15) begin
                n_bad++;
                $display("FAIL burst_timing[%0d]: pulses=%0d latency=%0d span=%0d, want 16 %0d 15",
                         k, got[k].size(), first_t[k] + 1, last_t[k] - first_t[k], lat[k]);
            end
            for (int i = 0; i < got[k].size() && i < 16; i++) begin
                n_cmp++;
                if (got[k][i] !== 16'(255 - i)) begin
                    n_bad++;
                    $display("FAIL burst_value[%0d] addr %0d: got %h, want %h", k, i, got[k][i], 16'(255 - i));
                end
            end
        end
    endtask

    task automatic test_byte_lanes();
        wren = 1'b1; wraddress = 8'd3; byteena = 2'b11; data = 16'hABCD;
        step();
        byteena = 2'b01; data = 16'h1234;
        step();
        wren = 1'b0; rden = 1'b1; rdaddress = 8'd3;
        step();
        rden = 1'b0;
        n_cmp++;
        if (rv[0] !== 1'b1 || dout[0] !== 16'h0034) begin
            n_bad++;
            $display("FAIL lanes_a: rdvalid=%b q=%h, want 1 0034", rv[0], dout[0]);
        end
        step();
        n_cmp++;
        if (rv[0] !== 1'b0 || dout[0] !== 16'h0034) begin
            n_bad++;
            $display("FAIL lanes_a_hold: rdvalid=%b q=%h, want 0 0034", rv[0], dout[0]);
        end
        n_cmp++;
        if (rv[1] !== 1'b1 || dout[1] !== 16'h0034) begin
            n_bad++;
            $display("FAIL lanes_b: rdvalid=%b q=%h, want 1 0034", rv[1], dout[1]);
        end
        n_cmp++;
        if (rv[2] !== 1'b1 || dout[2] !== 16'hAB34) begin
            n_bad++;
            $display("FAIL lanes_c: rdvalid=%b q=%h, want 1 AB34", rv[2], dout[2]);
        end
    endtask

    task automatic test_rdw();
        wren = 1'b1; wraddress = 8'd5; byteena = 2'b11; data = 16'h0011;
        step();
        // Collision edge: only the low lane is enabled, so instance c must
        // merge 22 into 0011 and keep its upper byte.
        byteena = 2'b01; data = 16'h7722; rden = 1'b1; rdaddress = 8'd5;
        step();
        wren = 1'b0; rden = 1'b0;
        n_cmp++;
        if (rv[0] !== 1'b1 || dout[0] !== 16'h0011) begin
            n_bad++;
            $display("FAIL rdw_old_a: rdvalid=%b q=%h, want 1 0011", rv[0], dout[0]);
        end
        step();
        n_cmp++;
        if (rv[1] !== 1'b1 || dout[1] !== 16'h0022) begin
            n_bad++;
            $display("FAIL rdw_new_b: rdvalid=%b q=%h, want 1 0022", rv[1], dout[1]);
        end
        n_cmp++;
        if (rv[2] !== 1'b1 || dout[2] !== 16'h0022) begin
            n_bad++;
            $display("FAIL rdw_new_c: rdvalid=%b q=%h, want 1 0022", rv[2], dout[2]);
        end
        rden = 1'b1; rdaddress = 8'd5;
        step();
        rden = 1'b0;
        n_cmp++;
        if (rv[0] !== 1'b1 || dout[0] !== 16'h0022) begin
            n_bad++;
            $display("FAIL rdw_after_a: rdvalid=%b q=%h, want 1 0022", rv[0], dout[0]);
        end
        step();
        for (int k = 1; k < 3; k++) begin
            n_cmp++;
            if (rv[k] !== 1'b1 || dout[k] !== 16'h0022) begin
                n_bad++;
                $display("FAIL rdw_after[%0d]: rdvalid=%b q=%h, want 1 0022", k, rv[k], dout[k]);
            end
        end
    endtask

    task automatic test_reset_midread();
        int  cnt [3];
        logic seen [3];
        wren = 1'b1; wraddress = 8'd7; byteena = 2'b11; data = 16'h5A5A;
        step();
        wren = 1'b0; rden = 1'b1; rdaddress = 8'd7;
        step();
        rden = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rv[k] !== 1'b0 || dout[k] !== 16'h0000 || bz[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL midread_reset[%0d]: rdvalid=%b q=%h busy=%b, want 0 0000 1", k, rv[k], dout[k], bz[k]);
            end
        end
        cnt  = '{0, 0, 0};
        seen = '{1'b0, 1'b0, 1'b0};
        for (int t = 0; t < 300; t++) begin
            for (int k = 0; k < 3; k++) begin
                if (bz[k]) cnt[k]++;
                if (rv[k]) seen[k] = 1'b1;
            end
            if (!bz[0] && !bz[1] && !bz[2]) break;
            step();
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (cnt[k] != DEPTH || seen[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL midread_clear[%0d]: busy_cycles=%0d stray_rdvalid=%b, want %0d 0", k, cnt[k], seen[k], DEPTH);
            end
        end
        rden = 1'b1; rdaddress = 8'd7;
        step();
        rden = 1'b0;
        n_cmp++;
        if (rv[0] !== 1'b1 || dout[0] !== init_v[0]) begin
            n_bad++;
            $display("FAIL midread_reread_a: rdvalid=%b q=%h, want 1 %h", rv[0], dout[0], init_v[0]);
        end
        step();
        for (int k = 1; k < 3; k++) begin
            n_cmp++;
            if (rv[k] !== 1'b1 || dout[k] !== init_v[k]) begin
                n_bad++;
                $display("FAIL midread_reread[%0d]: rdvalid=%b q=%h, want 1 %h", k, rv[k], dout[k], init_v[k]);
            end
        end
    endtask

    task automatic test_busy_ignores();
        logic seen [3];
        logic qnz [3];
        reset = 1'b1;
        step();
        reset = 1'b0;
        wren = 1'b1; wraddress = 8'd0; data = 16'hFFFF; byteena = 2'b11;
        rden = 1'b1; rdaddress = 8'd0;
        seen = '{1'b0, 1'b0, 1'b0};
        qnz  = '{1'b0, 1'b0, 1'b0};
        for (int t = 0; t < 300; t++) begin
            if (!bz[0] && !bz[1] && !bz[2]) break;
            for (int k = 0; k < 3; k++) begin
                if (rv[k]) seen[k] = 1'b1;
                if (dout[k] !== 16'h0000) qnz[k] = 1'b1;
            end
            step();
        end
        wren = 1'b0; rden = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (seen[k] !== 1'b0 || qnz[k] !== 1'b0 || bz[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL busy_ignore[%0d]: rdvalid_seen=%b q_nonzero=%b busy_end=%b, want 0 0 0",
                         k, seen[k], qnz[k], bz[k]);
            end
        end
        rden = 1'b1; rdaddress = 8'd0;
        step();
        rden = 1'b0;
        n_cmp++;
        if (rv[0] !== 1'b1 || dout[0] !== init_v[0]) begin
            n_bad++;
            $display("FAIL busy_write_dropped_a: rdvalid=%b q=%h, want 1 %h", rv[0], dout[0], init_v[0]);
        end
        step();
        for (int k = 1; k < 3; k++) begin
            n_cmp++;
            if (rv[k] !== 1'b1 || dout[k] !== init_v[k]) begin
                n_bad++;
                $display("FAIL busy_write_dropped[%0d]: rdvalid=%b q=%h, want 1 %h", k, rv[k], dout[k], init_v[k]);
            end
        end
    endtask

    task automatic test_random();
        int rst_at;
        rst_at = $urandom_range(150, 300);
        for (int t = 0; t < 900; t++) begin
            reset     = (t == rst_at);
            wren      = 1'($urandom_range(0, 1));
            rden      = 1'($urandom_range(0, 1));
            data      = 16'($urandom);
            byteena   = 2'($urandom);
            wraddress = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) rdaddress = wraddress;
            else rdaddress = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            step();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dout[k] !== exp_dout[k] || rv[k] !== exp_rv[k] || bz[k] !== (busy_left[k] > 0)) begin
                    n_bad++;
                    $display("FAIL random[%0d] cycle %0d: q=%h rdvalid=%b busy=%b, want %h %b %b",
                             k, t, dout[k], rv[k], bz[k], exp_dout[k], exp_rv[k], busy_left[k] > 0);
                end
            end
        end
        reset = 1'b0; wren = 1'b0; rden = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lat    = '{1, 2, 2};
        rdw    = '{1'b0, 1'b1, 1'b1};
        nb     = '{1, 1, 2};
        init_v = '{16'h0000, 16'h0000, 16'hA5C3};
        for (int k = 0; k < 3; k++) begin
            busy_left[k] = 0;
            exp_dout[k]  = 16'h0000;
            exp_rv[k]    = 1'b0;
        end
        reset = 1'b1; wren = 1'b0; rden = 1'b0; data = 16'h0000;
        wraddress = 8'd0; rdaddress = 8'd0; byteena = 2'b00;

        test_reset();
        test_clear_contents();
        test_burst();
        test_byte_lanes();
        test_rdw();
        test_reset_midread();
        test_busy_ignores();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
